// File: rtl/ans_bit_packer.sv
// MSB-first bit packer for the ANS encoder: appends variable-length chunks to a
// left-aligned accumulator and emits bytes, zero-padding the final byte on flush.
module ans_bit_packer #(
    parameter  int MAX_BITS = 16,
    localparam int ACC      = MAX_BITS + 8,
    localparam int NBW      = $clog2(MAX_BITS + 1),
    localparam int FW       = $clog2(ACC + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAX_BITS-1:0] in_bits,
    input  logic [NBW-1:0]      in_nbits,
    input  logic                in_flush,
    input  logic                in_vld,
    output logic                in_rdy,
    output logic [7:0]          out,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic                out_last,
    output logic [3:0]          out_pad,
    output logic [FW-1:0]       dbg_fill,
    output logic                dbg_mode
);

    // Handshakes: a beat transfers on a rising edge where valid && ready are both 1;
    // valid never depends on ready, and neither ready nor valid depends on inputs.
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} mode_t;

    mode_t            r_mode, w_mode_nxt;
    logic [ACC-1:0]   r_acc, w_acc_nxt;
    logic [FW-1:0]    r_fill, w_fill_nxt;

    logic [NBW-1:0]   w_n;
    logic [ACC-1:0]   w_chunk;
    logic [FW-1:0]    w_shamt;
    logic             w_accept;
    logic             w_drain;

    assign in_rdy   = (r_mode == RUN) && (r_fill < FW'(8));
    assign out_vld  = (r_fill >= FW'(8)) || (r_mode == FLUSH);
    assign out_last = (r_mode == FLUSH) && (r_fill <= FW'(8));
    assign out_pad  = out_last ? (4'd8 - r_fill[3:0]) : 4'd0;
    assign out      = r_acc[ACC-1 -: 8];
    assign dbg_fill = r_fill;
    assign dbg_mode = r_mode;

    assign w_accept = in_vld && in_rdy;
    assign w_drain  = out_vld && out_rdy;

    always_comb begin
        w_n        = (in_nbits > NBW'(MAX_BITS)) ? NBW'(MAX_BITS) : in_nbits;
        w_chunk    = ACC'(in_bits) & ((ACC'(1) << w_n) - ACC'(1));
        // Accept only happens with fill <= 7, so this never underflows.
        w_shamt    = FW'(ACC) - r_fill - FW'(w_n);
        w_acc_nxt  = r_acc;
        w_fill_nxt = r_fill;
        w_mode_nxt = r_mode;
        if (w_accept) begin
            w_acc_nxt  = r_acc | (w_chunk << w_shamt);
            w_fill_nxt = r_fill + FW'(w_n);
            if (in_flush) begin
                w_mode_nxt = FLUSH;
            end
        end else if (w_drain) begin
            if (out_last) begin
                w_acc_nxt  = '0;
                w_fill_nxt = '0;
                w_mode_nxt = RUN;
            end else begin
                w_acc_nxt  = r_acc << 8;
                w_fill_nxt = r_fill - FW'(8);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_mode <= RUN;
        end else begin
            r_acc  <= w_acc_nxt;
            r_fill <= w_fill_nxt;
            r_mode <= w_mode_nxt;
        end
    end

endmodule

// File: tb/tb_ans_bit_packer.sv
// Directed plus randomized bench for ans_bit_packer: a bit-queue reference model
// feeds an expected-byte queue that a negedge monitor pops on each output handshake.
module tb_ans_bit_packer;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_bits;
  logic [4:0]  in_nbits;
  logic        in_flush;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  out;
  logic        out_vld;
  logic        out_rdy;
  logic        out_last;
  logic [3:0]  out_pad;
  logic [4:0]  dbg_fill;
  logic        dbg_mode;

  int n_checks = 0;
  int n_pass   = 0;
  logic [12:0] exp_q[$];
  bit          mbits[$];
  bit          rand_en = 0;

  ans_bit_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_bits  (in_bits),
    .in_nbits (in_nbits),
    .in_flush (in_flush),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out      (out),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last),
    .out_pad  (out_pad),
    .dbg_fill (dbg_fill),
    .dbg_mode (dbg_mode)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference model: stream of bits, cut into expected bytes
  task automatic push_byte(input bit last, input logic [3:0] pad);
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) b[i] = mbits.pop_front();
    exp_q.push_back({last, pad, b});
  endtask

  task automatic model(input logic [15:0] b, input int nb, input bit f);
    int n;
    n = (nb > 16) ? 16 : nb;
    for (int i = n - 1; i >= 0; i--) mbits.push_back(b[i]);
    while (mbits.size() > 8 || (!f && mbits.size() == 8)) push_byte(1'b0, 4'd0);
    if (f) begin
      if (mbits.size() == 0) begin
        exp_q.push_back({1'b1, 4'd8, 8'h00});
      end else begin
        logic [3:0] pad;
        pad = 4'(8 - mbits.size());
        while (mbits.size() < 8) mbits.push_back(1'b0);
        push_byte(1'b1, pad);
      end
    end
  endtask

  // driver: called at posedge+#1; returns at posedge+#1 after the accept edge
  task automatic send(input logic [15:0] b, input int nb, input bit f);
    int cnt;
    cnt = 0;
    model(b, nb, f);
    in_bits  = b;
    in_nbits = 5'(nb);
    in_flush = f;
    in_vld   = 1'b1;
    while (!in_rdy && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_checks++;
    assert (cnt < 200) n_pass++;
    else $error("FAIL send_timeout: waited %0d cycles, limit %0d", cnt, 200);
    @(posedge clk);
    #1;
    in_vld   = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: outputs are stable at negedge, handshake completes at next posedge
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      n_checks++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL unexpected_byte: observed %0h expected none", {out_last, out_pad, out});
      if (exp_q.size() != 0) begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("byte_stream", {3'b0, out_last, out_pad, out}, {3'b0, e});
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    in_bits  = 16'hBEEF;
    in_nbits = 5'd9;
    in_flush = 1'b1;
    in_vld   = 1'b1;
    out_rdy  = 1'b0;
    repeat (3) tick();
    // reset state with arbitrary inputs applied
    check("rst_in_rdy", 16'(in_rdy), 16'h1);
    check("rst_out_vld", 16'(out_vld), 16'h0);
    check("rst_out", 16'(out), 16'h00);
    check("rst_out_last", 16'(out_last), 16'h0);
    check("rst_out_pad", 16'(out_pad), 16'h0);
    in_vld   = 1'b0;
    in_flush = 1'b0;
    out_rdy  = 1'b1;
    rst_n    = 1'b1;
    repeat (3) tick();
    check("idle_in_rdy", 16'(in_rdy), 16'h1);
    check("idle_out_vld", 16'(out_vld), 16'h0);
    check("idle_fill", 16'(dbg_fill), 16'h0);

    // nibble packing
    send(16'hA, 4, 0);
    send(16'h5, 4, 0);
    check("nib_vld", 16'(out_vld), 16'h1);
    check("nib_out", 16'(out), 16'hA5);
    check("nib_last", 16'(out_last), 16'h0);
    tick();
    check("nib_in_rdy", 16'(in_rdy), 16'h1);
    check("nib_vld_after", 16'(out_vld), 16'h0);

    // wide chunk, upper bits masked
    send(16'hF234, 12, 0);
    check("wide_out0", 16'(out), 16'h23);
    check("wide_rdy0", 16'(in_rdy), 16'h0);
    send(16'hC, 4, 0);
    check("wide_out1", 16'(out), 16'h4C);
    check("wide_rdy1", 16'(in_rdy), 16'h0);
    tick();
    check("wide_in_rdy", 16'(in_rdy), 16'h1);

    // flush with pad
    send(16'h5, 3, 1);
    check("pad_out", 16'(out), 16'hA0);
    check("pad_last", 16'(out_last), 16'h1);
    check("pad_pad", 16'(out_pad), 16'h5);
    check("pad_rdy", 16'(in_rdy), 16'h0);
    tick();
    check("pad_in_rdy", 16'(in_rdy), 16'h1);
    check("pad_fill", 16'(dbg_fill), 16'h0);

    // empty flush and aligned flush
    send(16'h0, 0, 1);
    check("empty_vld", 16'(out_vld), 16'h1);
    check("empty_out", 16'(out), 16'h00);
    check("empty_last", 16'(out_last), 16'h1);
    check("empty_pad", 16'(out_pad), 16'h8);
    tick();
    send(16'hAB, 8, 1);
    check("align_out", 16'(out), 16'hAB);
    check("align_last", 16'(out_last), 16'h1);
    check("align_pad", 16'(out_pad), 16'h0);
    tick();
    check("align_in_rdy", 16'(in_rdy), 16'h1);

    // backpressure then reset mid-stream
    out_rdy = 1'b0;
    send(16'h1234, 16, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 16'(out_vld), 16'h1);
      check("bp_out", 16'(out), 16'h12);
      check("bp_rdy", 16'(in_rdy), 16'h0);
      tick();
    end
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("bp_left", 16'(exp_q.size()), 16'h1);
    rst_n = 1'b0;
    exp_q.delete();
    mbits.delete();
    #1;
    check("rst_mid_vld", 16'(out_vld), 16'h0);
    check("rst_mid_rdy", 16'(in_rdy), 16'h1);
    tick();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    repeat (3) tick();
    check("rst_mid_after_vld", 16'(out_vld), 16'h0);
    check("rst_mid_after_fill", 16'(dbg_fill), 16'h0);

    // random chunks (including oversize lengths) under random backpressure
    rand_en = 1;
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), int'($urandom_range(0, 20)), 1'b0);
    end
    send(16'($urandom), int'($urandom_range(0, 16)), 1'b1);
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 1000) begin
      tick();
      cnt++;
    end
    rand_en = 0;
    out_rdy = 1'b1;
    check("rand_drained", 16'(exp_q.size()), 16'h0);
    tick();
    check("rand_end_rdy", 16'(in_rdy), 16'h1);
    check("rand_end_vld", 16'(out_vld), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
